// File: rtl/main_memory_ctrl.sv
// Main memory for the microcoded CPU: wait-stated byte/half/word access, ACK pulse in cycle N+WAIT_STATES+2.
// No backpressure beyond the handshake: request is held until ACK, then must drop before the next access.
module main_memory_ctrl #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH     = 10,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     MAIN_MEMORY_CTRL_CLOCK_50,
  input  logic                     MAIN_MEMORY_CTRL_ResetInHigh_In,
  input  logic                     MAIN_MEMORY_CTRL_RD_In,
  input  logic                     MAIN_MEMORY_CTRL_WRMain_In,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_CTRL_A_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_CTRL_B_InBus,
  input  logic [1:0]               MAIN_MEMORY_CTRL_Size_InBus,
  output logic                     MAIN_MEMORY_CTRL_ACK_Out,
  output logic                     MAIN_MEMORY_CTRL_Error_Out,
  output logic                     MAIN_MEMORY_CTRL_Busy_Out,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_CTRL_Data_OutBus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_RELEASE} state_t;

  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic clk, rst, req;
  assign clk = MAIN_MEMORY_CTRL_CLOCK_50;
  assign rst = MAIN_MEMORY_CTRL_ResetInHigh_In;
  assign req = MAIN_MEMORY_CTRL_RD_In | MAIN_MEMORY_CTRL_WRMain_In;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [ADDRWIDTH+1:0]   addr_q;
  logic [31:0]            wdat_q;
  logic [1:0]             size_q;
  logic                   wr_q, err_q;
  logic                   ack_q, error_q, busy_q;
  logic [31:0]            data_q;
  logic [31:0]            mem_q [2**ADDRWIDTH];

  // Request legality, evaluated on the live inputs at the moment of sampling.
  logic req_err_d, align_err;
  always_comb begin
    align_err = 1'b0;
    case (MAIN_MEMORY_CTRL_Size_InBus)
      2'b00:   align_err = 1'b0;
      2'b01:   align_err = MAIN_MEMORY_CTRL_A_InBus[0];
      2'b10:   align_err = (MAIN_MEMORY_CTRL_A_InBus[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
    req_err_d = align_err
              | (MAIN_MEMORY_CTRL_A_InBus[DATAWIDTH_BUS-1:ADDRWIDTH+2] != '0)
              | (MAIN_MEMORY_CTRL_RD_In & MAIN_MEMORY_CTRL_WRMain_In);
  end

  logic [ADDRWIDTH-1:0] word_idx;
  logic [31:0]          rd_word, rd_shift, rd_ext_d, lane_mask, lane_dat, wr_word_d;
  logic [4:0]           byte_sh;

  assign word_idx = addr_q[ADDRWIDTH+1:2];
  assign rd_word  = mem_q[word_idx];
  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  assign byte_sh  = {2'd3 - addr_q[1:0], 3'b000};
  assign rd_shift = rd_word >> byte_sh;

  always_comb begin
    rd_ext_d  = rd_word;
    lane_mask = 32'hFFFF_FFFF;
    lane_dat  = wdat_q;
    case (size_q)
      2'b00: begin
        rd_ext_d  = {24'h0, rd_shift[7:0]};
        lane_mask = 32'h0000_00FF << byte_sh;
        lane_dat  = {24'h0, wdat_q[7:0]} << byte_sh;
      end
      2'b01: begin
        rd_ext_d  = {16'h0, (addr_q[1] ? rd_word[15:0] : rd_word[31:16])};
        lane_mask = addr_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        lane_dat  = addr_q[1] ? {16'h0, wdat_q[15:0]} : {wdat_q[15:0], 16'h0};
      end
      default: ;
    endcase
    wr_word_d = (rd_word & ~lane_mask) | (lane_dat & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req) begin
          addr_q  <= MAIN_MEMORY_CTRL_A_InBus[ADDRWIDTH+1:0];
          wdat_q  <= MAIN_MEMORY_CTRL_B_InBus;
          size_q  <= MAIN_MEMORY_CTRL_Size_InBus;
          wr_q    <= MAIN_MEMORY_CTRL_WRMain_In;
          err_q   <= req_err_d;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) state_q <= S_ACCESS;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        S_ACCESS: begin
          if (!err_q && !wr_q) data_q <= rd_ext_d;
          ack_q   <= 1'b1;
          error_q <= err_q;
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_RELEASE;
        S_RELEASE: if (!req) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Array is deliberately left out of reset; only a write reaching ACCESS commits.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_ACCESS && wr_q && !err_q) mem_q[word_idx] <= wr_word_d;
  end

  assign MAIN_MEMORY_CTRL_ACK_Out     = ack_q;
  assign MAIN_MEMORY_CTRL_Error_Out   = error_q;
  assign MAIN_MEMORY_CTRL_Busy_Out    = busy_q;
  assign MAIN_MEMORY_CTRL_Data_OutBus = data_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: cycle-level reference model compared every cycle, plus directed literal checks.
module tb_main_memory_ctrl;
  localparam int W  = 2;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [1:0]  size = '0;
  logic ack, err, busy;
  logic [31:0] data;

  logic rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0;
  logic [1:0]  size0 = '0;
  logic ack0, err0, busy0;
  logic [31:0] data0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  main_memory_ctrl #(.DATAWIDTH_BUS(32), .ADDRWIDTH(AW), .WAIT_STATES(W)) dut (
    .MAIN_MEMORY_CTRL_CLOCK_50(clk), .MAIN_MEMORY_CTRL_ResetInHigh_In(rst),
    .MAIN_MEMORY_CTRL_RD_In(rd), .MAIN_MEMORY_CTRL_WRMain_In(wr),
    .MAIN_MEMORY_CTRL_A_InBus(a), .MAIN_MEMORY_CTRL_B_InBus(b),
    .MAIN_MEMORY_CTRL_Size_InBus(size), .MAIN_MEMORY_CTRL_ACK_Out(ack),
    .MAIN_MEMORY_CTRL_Error_Out(err), .MAIN_MEMORY_CTRL_Busy_Out(busy),
    .MAIN_MEMORY_CTRL_Data_OutBus(data));

  main_memory_ctrl #(.DATAWIDTH_BUS(32), .ADDRWIDTH(AW), .WAIT_STATES(0)) dut0 (
    .MAIN_MEMORY_CTRL_CLOCK_50(clk), .MAIN_MEMORY_CTRL_ResetInHigh_In(rst),
    .MAIN_MEMORY_CTRL_RD_In(rd0), .MAIN_MEMORY_CTRL_WRMain_In(wr0),
    .MAIN_MEMORY_CTRL_A_InBus(a0), .MAIN_MEMORY_CTRL_B_InBus(b0),
    .MAIN_MEMORY_CTRL_Size_InBus(size0), .MAIN_MEMORY_CTRL_ACK_Out(ack0),
    .MAIN_MEMORY_CTRL_Error_Out(err0), .MAIN_MEMORY_CTRL_Busy_Out(busy0),
    .MAIN_MEMORY_CTRL_Data_OutBus(data0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction sampled at edge e completes (ACK) at edge e+W+1.
  logic [31:0] mmem [int unsigned];
  int          ph = 0, rem = 0;
  logic        m_ack = 0, m_err = 0, m_busy = 0;
  logic [31:0] m_data = 0;
  logic        l_wr, l_err;
  logic [31:0] l_a, l_b;
  logic [1:0]  l_size;

  function automatic logic model_err(logic r, logic w, logic [31:0] aa, logic [1:0] sz);
    int nbytes;
    if (sz == 2'b11) return 1'b1;
    nbytes = 1 << sz;
    if ((aa % nbytes) != 0) return 1'b1;
    if (aa >= (4 << AW)) return 1'b1;
    return r && w;
  endfunction

  initial begin
    logic s_rst, s_rd, s_wr;
    logic [31:0] s_a, s_b, word, mask;
    logic [1:0] s_size;
    int sh;
    forever begin
      @(posedge clk);
      s_rst = rst; s_rd = rd; s_wr = wr; s_a = a; s_b = b; s_size = size;
      if (s_rst) begin
        ph = 0; m_ack = 0; m_err = 0; m_busy = 0; m_data = 0;
      end else begin
        m_ack = 0; m_err = 0;
        case (ph)
          0: if (s_rd || s_wr) begin
            l_wr = s_wr; l_a = s_a; l_b = s_b; l_size = s_size;
            l_err = model_err(s_rd, s_wr, s_a, s_size);
            rem = W + 1; ph = 1; m_busy = 1;
          end
          1: begin
            rem--;
            if (rem == 0) begin
              if (!l_err) begin
                word = mmem.exists(l_a / 4) ? mmem[l_a / 4] : 32'h0;
                sh = (l_size == 2'b00) ? 8 * (3 - int'(l_a % 4)) :
                     (l_size == 2'b01) ? 8 * (2 - int'(l_a % 4)) : 0;
                mask = (l_size == 2'b00) ? 32'hFF : (l_size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
                if (l_wr) mmem[l_a / 4] = (word & ~(mask << sh)) | ((l_b & mask) << sh);
                else      m_data = (word >> sh) & mask;
              end
              m_ack = 1; m_err = l_err; ph = 2;
            end
          end
          2: ph = 3;
          default: if (!s_rd && !s_wr) begin ph = 0; m_busy = 0; end
        endcase
      end
      @(negedge clk);
      chk("model_ack",  {31'h0, ack},  {31'h0, m_ack});
      chk("model_err",  {31'h0, err},  {31'h0, m_err});
      chk("model_busy", {31'h0, busy}, {31'h0, m_busy});
      chk("model_data", data, m_data);
    end
  end

  // Issues one request on dut (sel=0) or dut0 (sel=1), returns ACK latency and outputs seen with ACK.
  task automatic do_req(input bit sel, input logic r, input logic w, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [1:0] sz,
                        output int lat, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    if (sel) begin rd0 = r; wr0 = w; a0 = aa; b0 = bb; size0 = sz; end
    else     begin rd  = r; wr  = w; a  = aa; b  = bb; size  = sz; end
    lat = -1; d = 'x; e = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((sel ? ack0 : ack) === 1'b1) begin
        lat = k; d = sel ? data0 : data; e = sel ? err0 : err;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=none required=ACK within 40 cycles");
    end
    @(posedge clk); #1;
    rd = 0; wr = 0; rd0 = 0; wr0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((sel ? busy0 : busy) === 1'b0) break;
    end
  endtask

  initial begin
    int lat, n;
    logic [31:0] d;
    logic e;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_ack",  {31'h0, ack},  32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_data", data, 32'h0);

    // 1: word write then word read
    do_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, lat, d, e);
    chk("t1_wr_lat", lat, 4); chk("t1_wr_err", {31'h0, e}, 32'h0);
    do_req(0, 1, 0, 32'h10, 32'h0, 2'b10, lat, d, e);
    chk("t1_rd_lat", lat, 4); chk("t1_rd_data", d, 32'hDEADBEEF); chk("t1_rd_err", {31'h0, e}, 32'h0);

    // 2: byte write lane 1, readbacks
    do_req(0, 0, 1, 32'h11, 32'h000000AA, 2'b00, lat, d, e);
    do_req(0, 1, 0, 32'h10, 32'h0, 2'b10, lat, d, e);
    chk("t2_word", d, 32'hDEAABEEF);
    do_req(0, 1, 0, 32'h11, 32'h0, 2'b00, lat, d, e);
    chk("t2_byte", d, 32'h000000AA);

    // 3: half reads, aligned and misaligned
    do_req(0, 1, 0, 32'h12, 32'h0, 2'b01, lat, d, e);
    chk("t3_half", d, 32'h0000BEEF);
    do_req(0, 1, 0, 32'h13, 32'h0, 2'b01, lat, d, e);
    chk("t3_mis_err", {31'h0, e}, 32'h1); chk("t3_mis_data", d, 32'h0000BEEF);
    do_req(0, 1, 0, 32'h10, 32'h0, 2'b11, lat, d, e);
    chk("t3_size11_err", {31'h0, e}, 32'h1);

    // 4: held request produces a single ACK, re-arm gives another
    @(posedge clk); #1 rd = 1; a = 32'h10; size = 2'b10;
    n = 0;
    repeat (20) begin @(negedge clk); if (ack === 1'b1) n++; end
    chk("t4_one_ack", n, 1);
    @(posedge clk); #1 rd = 0;
    repeat (3) @(negedge clk);
    do_req(0, 1, 0, 32'h10, 32'h0, 2'b10, lat, d, e);
    chk("t4_rearm_lat", lat, 4); chk("t4_rearm_data", d, 32'hDEAABEEF);

    // 5: illegal requests leave the array alone
    do_req(0, 1, 1, 32'h10, 32'h0, 2'b10, lat, d, e);
    chk("t5_both_err", {31'h0, e}, 32'h1);
    do_req(0, 1, 0, 32'h10, 32'h0, 2'b10, lat, d, e);
    chk("t5_unchanged", d, 32'hDEAABEEF);
    do_req(0, 0, 1, 32'h0000_1000, 32'h55555555, 2'b10, lat, d, e);
    chk("t5_range_err", {31'h0, e}, 32'h1);

    // 6: reset during WAIT aborts the write
    do_req(0, 0, 1, 32'h20, 32'h12345678, 2'b10, lat, d, e);
    @(posedge clk); #1 wr = 1; a = 32'h20; b = 32'hFFFFFFFF; size = 2'b10;
    @(posedge clk); #1 rst = 1; wr = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_ack",  {31'h0, ack},  32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_data", data, 32'h0);
    do_req(0, 1, 0, 32'h20, 32'h0, 2'b10, lat, d, e);
    chk("t6_word_kept", d, 32'h12345678);

    // Zero wait states
    do_req(1, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, lat, d, e);
    chk("w0_wr_lat", lat, 2);
    do_req(1, 1, 0, 32'h10, 32'h0, 2'b10, lat, d, e);
    chk("w0_rd_lat", lat, 2); chk("w0_rd_data", d, 32'hDEADBEEF); chk("w0_rd_err", {31'h0, e}, 32'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
